// File: rtl/key_cmd_pkg.sv
// Shared types, command codes and width helpers for the key command encoder.
// Codes follow the function-3 key processor; CMD_NONE marks an empty queue.
package key_cmd_pkg;

    localparam int CMD_NONE = 0;
    localparam int NORTH    = 1;
    localparam int EAST     = 2;
    localparam int WEST     = 3;
    localparam int SOUTH    = 4;
    localparam int SCRAMBLE = 5;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Buttons are wired East, West, North, South, Scramble (index 0 first).
    function automatic int legacy_code(input int idx);
        case (idx)
            0:       return EAST;
            1:       return WEST;
            2:       return NORTH;
            3:       return SOUTH;
            4:       return SCRAMBLE;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one push-button.
// Ports: sysclk, reset (sync, active-high), key_raw (async), level (debounced).
module key_debounce
    import key_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic key_raw,
    output logic level
);

    localparam int CW = width_of(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], key_raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_cmd_encoder.sv
// Debounced keys -> one-shot / auto-repeat command codes through a small FIFO.
// Ports: sysclk, reset, keys_in, repeat_en, cmd_ready in; cmd_code, cmd_valid,
// keys_held, overflow out. Codes are index+1, or the legacy table if selected.
module key_cmd_encoder
    import key_cmd_pkg::*;
#(
    parameter int N_KEYS          = 5,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1000000,
    parameter int FIFO_DEPTH      = 4,
    parameter bit LEGACY_CODES    = 1'b0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic              repeat_en,
    output logic [CODE_W-1:0] cmd_code,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [N_KEYS-1:0] keys_held,
    output logic              overflow
);

    localparam int IDX_W   = width_of(N_KEYS);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = width_of(TMR_MAX);
    localparam int PTR_W   = width_of(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .sysclk (sysclk),
            .reset  (reset),
            .key_raw(keys_in[i]),
            .level  (keys_held[i])
        );
    end

    logic [N_KEYS-1:0] held_q;
    logic [N_KEYS-1:0] press;
    logic              press_any;
    logic [IDX_W-1:0]  win_idx;

    assign press     = keys_held & ~held_q;
    assign press_any = |press;

    // Lowest index wins; the losers are silently discarded.
    always_comb begin
        win_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press[i]) win_idx = IDX_W'(i);
        end
    end

    rpt_state_t       state, state_n;
    logic [TMR_W-1:0] timer, timer_n, limit;
    logic [IDX_W-1:0] held_idx, idx_n;
    logic             rpt_evt;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            held_idx <= '0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            held_idx <= idx_n;
        end
    end

    assign limit = (state == DELAY) ? TMR_W'(REPEAT_DELAY - 1)
                                    : TMR_W'(REPEAT_PERIOD - 1);

    // A fresh press restarts the delay and pre-empts a due repeat.
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = held_idx;
        rpt_evt = 1'b0;
        if (press_any) begin
            state_n = DELAY;
            timer_n = '0;
            idx_n   = win_idx;
        end else begin
            unique case (state)
                IDLE: ;
                DELAY, REPEAT: begin
                    if (!keys_held[held_idx] || !repeat_en) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end else if (timer == limit) begin
                        rpt_evt = 1'b1;
                        timer_n = '0;
                        state_n = REPEAT;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic              evt;
    logic [IDX_W-1:0]  evt_idx;
    logic [CODE_W-1:0] evt_code;

    assign evt     = press_any | rpt_evt;
    assign evt_idx = press_any ? win_idx : held_idx;

    always_comb begin
        evt_code = CODE_W'(evt_idx) + CODE_W'(1);
        if (LEGACY_CODES) evt_code = CODE_W'(legacy_code(int'(evt_idx)));
    end

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & cmd_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push  = evt & (~full | pop);

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= evt_code;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            held_q   <= '0;
            overflow <= 1'b0;
        end else begin
            held_q   <= keys_held;
            overflow <= evt & ~push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign cmd_valid = ~empty;
    assign cmd_code  = empty ? CODE_W'(CMD_NONE) : mem[rd_ptr];

endmodule

// File: tb/tb_key_cmd_encoder.sv
// Self-checking bench for key_cmd_encoder: directed scenarios plus a random
// run compared against a timestamp-based reference model of the key rules.
module tb_key_cmd_encoder;

    localparam int NK = 5;
    localparam int CW = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 4;
    localparam int FD = 4;

    logic          sysclk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_in;
    logic          repeat_en;
    logic          cmd_ready;
    logic [CW-1:0] cmd_code;
    logic          cmd_valid;
    logic [NK-1:0] keys_held;
    logic          overflow;

    always #5 sysclk = ~sysclk;

    key_cmd_encoder #(
        .N_KEYS         (NK),
        .CODE_W         (CW),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .FIFO_DEPTH     (FD),
        .LEGACY_CODES   (1'b0)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .keys_in  (keys_in),
        .repeat_en(repeat_en),
        .cmd_code (cmd_code),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .keys_held(keys_held),
        .overflow (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw-sample history, debounced levels, command queue,
    // and the absolute cycle at which the next repeat is due.
    logic [NK-1:0] m_hist [$];
    logic [NK-1:0] m_held, m_rise;
    logic [CW-1:0] m_q [$];
    logic          m_ovf, m_armed;
    int            m_idx, m_next, m_cycle;

    task automatic model_reset();
        m_hist = {};
        for (int k = 0; k <= DB; k++) m_hist.push_back('0);
        m_held  = '0;
        m_rise  = '0;
        m_q     = {};
        m_ovf   = 1'b0;
        m_armed = 1'b0;
        m_idx   = 0;
        m_next  = 0;
    endtask

    task automatic model_step();
        logic          ev;
        int            code;
        int            w;
        logic [NK-1:0] nh, smp;
        bit            differ;
        m_cycle++;
        if (reset) begin
            model_reset();
            return;
        end
        ev   = 1'b0;
        code = 0;
        if (m_rise != '0) begin
            w = 0;
            for (int i = NK - 1; i >= 0; i--) if (m_rise[i]) w = i;
            ev      = 1'b1;
            code    = w + 1;
            m_armed = 1'b1;
            m_idx   = w;
            m_next  = m_cycle + RD;
        end else if (m_armed) begin
            if (!m_held[m_idx] || !repeat_en) begin
                m_armed = 1'b0;
            end else if (m_cycle == m_next) begin
                ev     = 1'b1;
                code   = m_idx + 1;
                m_next = m_cycle + RP;
            end
        end
        if (m_q.size() > 0 && cmd_ready) void'(m_q.pop_front());
        m_ovf = 1'b0;
        if (ev) begin
            if (m_q.size() < FD) m_q.push_back(CW'(code));
            else m_ovf = 1'b1;
        end
        // A level flips once the last DB synchronised samples all disagree.
        nh = m_held;
        for (int i = 0; i < NK; i++) begin
            differ = 1'b1;
            for (int k = 1; k <= DB; k++) begin
                smp = m_hist[k];
                if (smp[i] == m_held[i]) differ = 1'b0;
            end
            if (differ) nh[i] = ~m_held[i];
        end
        m_rise = nh & ~m_held;
        m_held = nh;
        m_hist.push_front(keys_in);
        void'(m_hist.pop_back());
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        #1;
    endtask

    task automatic settle();
        keys_in   = '0;
        repeat_en = 1'b0;
        repeat (DB + 4) tick();
        cmd_ready = 1'b1;
        repeat (FD + 2) tick();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (cmd_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", cmd_valid);
        else n_pass++;
        n_checks++;
        if (cmd_code !== '0) $display("FAIL reset_code got=%0d want=0", cmd_code);
        else n_pass++;
        n_checks++;
        if (keys_held !== '0) $display("FAIL reset_held got=%b want=0", keys_held);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b want=0", overflow);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_latency();
        keys_in = 5'b00010;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) begin
                n_checks++;
                if (keys_held[1] !== 1'b0) $display("FAIL lat_held_early got=%b want=0", keys_held[1]);
                else n_pass++;
            end
            if (e == 5) begin
                n_checks++;
                if (keys_held[1] !== 1'b1 || cmd_valid !== 1'b0)
                    $display("FAIL lat_held got held=%b valid=%b want held=1 valid=0", keys_held[1], cmd_valid);
                else n_pass++;
            end
            if (e == 6) begin
                n_checks++;
                if (cmd_valid !== 1'b1 || cmd_code !== 4'd2)
                    $display("FAIL lat_cmd got valid=%b code=%0d want valid=1 code=2", cmd_valid, cmd_code);
                else n_pass++;
            end
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b0) $display("FAIL lat_pop got valid=%b want=0", cmd_valid);
        else n_pass++;
        settle();
    endtask

    task automatic test_glitch();
        keys_in = 5'b00001;
        repeat (3) tick();
        keys_in = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (keys_held !== '0 || cmd_valid !== 1'b0)
                $display("FAIL glitch c=%0d got held=%b valid=%b want held=0 valid=0", c, keys_held, cmd_valid);
            else n_pass++;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        keys_in = 5'b10100;
        repeat (7) tick();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 4'd3 || keys_held !== 5'b10100 || overflow !== 1'b0)
            $display("FAIL simul got valid=%b code=%0d held=%b ovf=%b want 1 3 10100 0",
                     cmd_valid, cmd_code, keys_held, overflow);
        else n_pass++;
        tick();
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL simul_ovf got=%b want=0", overflow);
        else n_pass++;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b0) $display("FAIL simul_single got valid=%b want=0", cmd_valid);
        else n_pass++;
        settle();
    endtask

    task automatic test_repeat();
        logic exp_v;
        repeat_en = 1'b1;
        cmd_ready = 1'b1;
        keys_in   = 5'b00001;
        for (int e = 0; e <= 45; e++) begin
            tick();
            exp_v = (e == 6) || (e >= 16 && (e - 16) % RP == 0);
            n_checks++;
            if (cmd_valid !== exp_v || cmd_code !== (exp_v ? 4'd1 : 4'd0))
                $display("FAIL repeat e=%0d got valid=%b code=%0d want valid=%b code=%0d",
                         e, cmd_valid, cmd_code, exp_v, exp_v ? 1 : 0);
            else n_pass++;
        end
        keys_in = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (cmd_valid !== (m_q.size() > 0) || keys_held !== m_held ||
                (c >= 8 && cmd_valid !== 1'b0))
                $display("FAIL repeat_stop c=%0d got valid=%b held=%b want valid=%b held=%b",
                         c, cmd_valid, keys_held, m_q.size() > 0, m_held);
            else n_pass++;
        end
        settle();
    endtask

    task automatic test_overflow();
        logic [CW-1:0] codes [5];
        logic [CW-1:0] exp_c [4];
        int            k;
        int            ovf_seen;
        repeat_en = 1'b0;
        cmd_ready = 1'b0;
        ovf_seen  = 0;
        for (int p = 0; p < 5; p++) begin
            k        = $urandom_range(0, NK - 1);
            codes[p] = CW'(k + 1);
            keys_in  = NK'(1) << k;
            repeat (DB + 3) begin
                tick();
                if (overflow === 1'b1) ovf_seen++;
            end
            keys_in = '0;
            repeat (DB + 3) begin
                tick();
                if (overflow === 1'b1) ovf_seen++;
            end
        end
        n_checks++;
        if (ovf_seen != 1) $display("FAIL ovf_pulses got=%0d want=1", ovf_seen);
        else n_pass++;
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== codes[0])
            $display("FAIL ovf_head got valid=%b code=%0d want valid=1 code=%0d", cmd_valid, cmd_code, codes[0]);
        else n_pass++;
        k       = $urandom_range(0, NK - 1);
        keys_in = NK'(1) << k;
        repeat (DB + 2) tick();
        cmd_ready = 1'b1;
        tick();
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL full_pop_ovf got=%b want=0", overflow);
        else n_pass++;
        exp_c[0] = codes[1];
        exp_c[1] = codes[2];
        exp_c[2] = codes[3];
        exp_c[3] = CW'(k + 1);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (cmd_valid !== 1'b1 || cmd_code !== exp_c[j])
                $display("FAIL fifo_order j=%0d got valid=%b code=%0d want valid=1 code=%0d",
                         j, cmd_valid, cmd_code, exp_c[j]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (cmd_valid !== 1'b0) $display("FAIL fifo_drained got valid=%b want=0", cmd_valid);
        else n_pass++;
        cmd_ready = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid();
        repeat_en = 1'b1;
        cmd_ready = 1'b0;
        keys_in   = 5'b01000;
        repeat (19) tick();
        n_checks++;
        if (cmd_valid !== 1'b1 || m_q.size() != 2)
            $display("FAIL mid_pre got valid=%b model_entries=%0d want valid=1 entries=2",
                     cmd_valid, m_q.size());
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b0 || cmd_code !== '0)
            $display("FAIL mid_reset got valid=%b code=%0d want 0 0", cmd_valid, cmd_code);
        else n_pass++;
        for (int e = 0; e <= 6; e++) begin
            tick();
            if (e == 4) begin
                n_checks++;
                if (keys_held !== '0) $display("FAIL mid_held_early got=%b want=0", keys_held);
                else n_pass++;
            end
            if (e == 5) begin
                n_checks++;
                if (keys_held !== 5'b01000 || cmd_valid !== 1'b0)
                    $display("FAIL mid_held got held=%b valid=%b want 01000 0", keys_held, cmd_valid);
                else n_pass++;
            end
            if (e == 6) begin
                n_checks++;
                if (cmd_valid !== 1'b1 || cmd_code !== 4'd4)
                    $display("FAIL mid_press got valid=%b code=%0d want 1 4", cmd_valid, cmd_code);
                else n_pass++;
            end
        end
        settle();
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_code;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0)
                keys_in = keys_in ^ (NK'(1) << $urandom_range(0, NK - 1));
            if ($urandom_range(0, 99) == 0) repeat_en = ~repeat_en;
            cmd_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
            exp_code = (m_q.size() > 0) ? m_q[0] : '0;
            n_checks++;
            if (keys_held !== m_held || cmd_valid !== (m_q.size() > 0) ||
                cmd_code !== exp_code || overflow !== m_ovf)
                $display("FAIL rand c=%0d got held=%b valid=%b code=%0d ovf=%b want held=%b valid=%b code=%0d ovf=%b",
                         c, keys_held, cmd_valid, cmd_code, overflow,
                         m_held, m_q.size() > 0, exp_code, m_ovf);
            else n_pass++;
        end
        reset = 1'b0;
        settle();
    endtask

    initial begin
        reset     = 1'b1;
        keys_in   = '0;
        repeat_en = 1'b0;
        cmd_ready = 1'b0;
        m_cycle   = 0;
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_repeat();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
